// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input port slave.
// Register offsets are also used by the address decoder.
package switch_input_port_pkg;

   localparam logic [1:0] SW_REG_STATE = 2'd0;
   localparam logic [1:0] SW_REG_EDGE  = 2'd1;
   localparam logic [1:0] SW_REG_COUNT = 2'd2;
   localparam logic [1:0] SW_REG_RSVD  = 2'd3;

endpackage

// File: rtl/switch_input_port_debounce_bit.sv
// One-bit synchronizer plus debouncer with rising-edge pulse.
// Ports: clk, reset (async high), rawIn, stable (debounced), rise (1-cycle).
module debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic rawIn,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign stable = stable_q;

   // The counter only runs while the synchronized input disagrees;
   // any agreeing cycle restarts the stability window.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise     = 1'b0;
      if (sync == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync;
         cnt_d    = '0;
         rise     = sync;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], rawIn};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped debounced switch input slave with sticky edge flags.
// Ports: clk, reset, sel, address, in, load (CPU bus); rawIn; out (read); state.
module switch_input_port
   import switch_input_port_pkg::*;
#(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic [1:0]       address,
   input  logic [15:0]      in,
   input  logic             load,
   input  logic [WIDTH-1:0] rawIn,
   output logic [15:0]      out,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] flag_q, flag_d;
   logic [WIDTH-1:0] clr;
   logic [15:0]      cnt_q, cnt_d;
   logic             wr;
   logic             unused_in;

   assign unused_in = ^in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .rawIn (rawIn[i]),
         .stable(stable[i]),
         .rise  (rise[i])
      );
   end

   assign state = stable;
   assign wr    = sel & load;

   // OR-ing rise after the clear lets a new edge survive a
   // same-cycle write-1-to-clear.
   always_comb begin
      clr = '0;
      if (wr && address == SW_REG_EDGE) clr = in[WIDTH-1:0];
      flag_d = (flag_q & ~clr) | rise;
   end

   // A CPU write to the counter overrides a coincident increment.
   always_comb begin
      cnt_d = cnt_q;
      if (wr && address == SW_REG_COUNT) cnt_d = in;
      else if (|rise)                    cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q <= '0;
         cnt_q  <= '0;
      end else begin
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      out = 16'h0000;
      if (sel) begin
         unique case (address)
            SW_REG_STATE: out = 16'(stable);
            SW_REG_EDGE:  out = 16'(flag_q);
            SW_REG_COUNT: out = cnt_q;
            SW_REG_RSVD:  out = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port.
// Directed scenarios plus random traffic against a behavioural model.
module tb_switch_input_port;

   localparam int W  = 10;
   localparam int SS = 2;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sel = 1'b0;
   logic          load = 1'b0;
   logic [1:0]    address = 2'd0;
   logic [15:0]   in = 16'h0;
   logic [W-1:0]  rawIn = '0;
   logic [15:0]   out;
   logic [W-1:0]  state;

   int errors = 0;
   int checks = 0;

   switch_input_port #(
      .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk(clk), .reset(reset), .sel(sel), .address(address),
      .in(in), .load(load), .rawIn(rawIn), .out(out), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: a bit's level flips once the board input, seen
   // SS samples late, has disagreed for DC consecutive clock samples.
   logic [W-1:0] m_state, m_flag, seen, rises;
   logic [15:0]  m_cnt;
   int           runlen [W];
   logic [W-1:0] hist [$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state = '0;
         m_flag  = '0;
         m_cnt   = '0;
         hist.delete();
         for (int i = 0; i < W; i++) runlen[i] = 0;
      end else begin
         seen = (hist.size() >= SS) ? hist[hist.size() - SS] : '0;
         hist.push_back(rawIn);
         if (hist.size() > SS + 1) hist.delete(0);
         rises = '0;
         for (int i = 0; i < W; i++) begin
            if (seen[i] != m_state[i]) begin
               runlen[i]++;
               if (runlen[i] == DC) begin
                  m_state[i] = seen[i];
                  runlen[i]  = 0;
                  rises[i]   = seen[i];
               end
            end else begin
               runlen[i] = 0;
            end
         end
         if (sel && load && address == 2'd1) m_flag = m_flag & ~in[W-1:0];
         m_flag = m_flag | rises;
         if (sel && load && address == 2'd2) m_cnt = in;
         else if (rises != '0)               m_cnt = m_cnt + 16'd1;
      end
   end

   function automatic logic [15:0] exp_out(logic s, logic [1:0] a);
      if (!s) return 16'h0000;
      case (a)
         2'd0:    return 16'(m_state);
         2'd1:    return 16'(m_flag);
         2'd2:    return m_cnt;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic rd(input logic [1:0] a, output logic [15:0] v);
      sel = 1'b1; load = 1'b0; address = a;
      #1 v = out;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      sel = 1'b1; load = 1'b1; address = a; in = d;
      @(negedge clk);
      sel = 1'b0; load = 1'b0; in = 16'h0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [15:0] v;
      #3;
      checks++; if (state !== '0) begin errors++; $display("FAIL rst_state got=%h exp=0", state); end
      rd(2'd0, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL rst_out got=%h exp=0", v); end
      @(negedge clk);
      reset = 1'b0; rawIn = 10'h3FF;
      cyc(8);
      checks++; if (state !== 10'h3FF) begin errors++; $display("FAIL pre_state got=%h exp=3ff", state); end
      @(posedge clk); #2 reset = 1'b1;
      #1;
      checks++; if (state !== '0) begin errors++; $display("FAIL mid_rst_state got=%h exp=0", state); end
      for (int a = 0; a < 3; a++) begin
         rd(2'(a), v);
         checks++; if (v !== 16'h0) begin errors++; $display("FAIL mid_rst_out a=%0d got=%h exp=0", a, v); end
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (state !== ((k < 6) ? 10'h000 : 10'h3FF)) begin
            errors++; $display("FAIL rel_lat k=%0d got=%h", k, state);
         end
      end
   endtask

   task automatic test_glitch;
      logic [15:0] v;
      rawIn = '0;
      cyc(10);
      rd(2'd2, v);
      checks++; if (v !== 16'h0001) begin errors++; $display("FAIL fall_cnt got=%h exp=0001", v); end
      rd(2'd1, v);
      checks++; if (v !== 16'h03FF) begin errors++; $display("FAIL fall_flag got=%h exp=03ff", v); end
      wr(2'd1, 16'hFFFF);
      wr(2'd2, 16'h0000);
      rawIn[0] = 1'b1;
      cyc(3);
      rawIn[0] = 1'b0;
      cyc(10);
      checks++; if (state !== '0) begin errors++; $display("FAIL glitch_state got=%h exp=0", state); end
      rd(2'd1, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL glitch_flag got=%h exp=0", v); end
      rd(2'd2, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL glitch_cnt got=%h exp=0", v); end
   endtask

   task automatic test_press;
      logic [15:0] v;
      @(negedge clk);
      rawIn[3] = 1'b1;
      cyc(10);
      checks++; if (state !== 10'h008) begin errors++; $display("FAIL press_state got=%h exp=008", state); end
      rd(2'd1, v);
      checks++; if (v !== 16'h0008) begin errors++; $display("FAIL press_flag got=%h exp=0008", v); end
      rd(2'd2, v);
      checks++; if (v !== 16'h0001) begin errors++; $display("FAIL press_cnt got=%h exp=0001", v); end
      wr(2'd1, 16'h0008);
      rd(2'd1, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL w1c got=%h exp=0", v); end
      rawIn[3] = 1'b0;
      cyc(10);
   endtask

   task automatic test_wrap;
      logic [15:0] v;
      wr(2'd2, 16'hFFFF);
      rd(2'd2, v);
      checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL cnt_load got=%h exp=ffff", v); end
      rawIn[1] = 1'b1;
      cyc(10);
      rawIn[1] = 1'b0;
      cyc(10);
      rd(2'd2, v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", v); end
   endtask

   task automatic test_race;
      logic [15:0] v, c0;
      rd(2'd2, c0);
      @(negedge clk);
      rawIn[5] = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (state[5] !== 1'b0) begin errors++; $display("FAIL race_early got=%b exp=0", state[5]); end
      sel = 1'b1; load = 1'b1; address = 2'd1; in = 16'h0020;
      @(negedge clk);
      sel = 1'b0; load = 1'b0; in = 16'h0;
      checks++; if (state[5] !== 1'b1) begin errors++; $display("FAIL race_rise got=%b exp=1", state[5]); end
      rd(2'd1, v);
      checks++; if (v[5] !== 1'b1) begin errors++; $display("FAIL race_flag got=%h exp=bit5", v); end
      rd(2'd2, v);
      checks++; if (v !== c0 + 16'd1) begin errors++; $display("FAIL race_cnt got=%h exp=%h", v, c0 + 16'd1); end
      rawIn[5] = 1'b0;
      cyc(10);
   endtask

   task automatic test_unselected;
      logic [15:0] v;
      @(negedge clk);
      sel = 1'b0; address = 2'd1; load = 1'b1; in = 16'hFFFF;
      #1;
      checks++; if (out !== 16'h0) begin errors++; $display("FAIL unsel_out got=%h exp=0", out); end
      @(negedge clk);
      load = 1'b0; in = 16'h0;
      rd(2'd1, v);
      checks++; if (v !== 16'h0022) begin errors++; $display("FAIL unsel_flag got=%h exp=0022", v); end
      wr(2'd0, 16'hFFFF);
      wr(2'd3, 16'hFFFF);
      rd(2'd0, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL ro_state got=%h exp=0", v); end
      rd(2'd3, v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL rsvd got=%h exp=0", v); end
      rd(2'd1, v);
      checks++; if (v !== 16'h0022) begin errors++; $display("FAIL ro_flag got=%h exp=0022", v); end
      rd(2'd2, v);
      checks++; if (v !== exp_out(1'b1, 2'd2)) begin errors++; $display("FAIL ro_cnt got=%h exp=%h", v, exp_out(1'b1, 2'd2)); end
   endtask

   task automatic test_random;
      int idx;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) begin
            idx = $urandom_range(0, W - 1);
            rawIn[idx] = ~rawIn[idx];
         end
         sel     = 1'($urandom_range(0, 3) != 0);
         address = 2'($urandom_range(0, 3));
         load    = 1'($urandom_range(0, 15) == 0);
         in      = 16'($urandom);
         #1;
         checks++;
         if (out !== exp_out(sel, address)) begin
            errors++;
            $display("FAIL rnd_out n=%0d a=%0d got=%h exp=%h", n, address, out, exp_out(sel, address));
         end
         checks++;
         if (state !== m_state) begin
            errors++; $display("FAIL rnd_state n=%0d got=%h exp=%h", n, state, m_state);
         end
      end
      @(negedge clk);
      sel = 1'b0; load = 1'b0; in = 16'h0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_press();
      test_wrap();
      test_race();
      test_unselected();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/switch_input_port.md
Name: switch_input_port

Overview:
Memory-mapped input responder on the Hack CPU data bus, the input-direction counterpart of the LED output port. It samples WIDTH raw board switches/buttons, synchronizes and debounces them, and captures rising edges in sticky, write-1-to-clear flags. It also counts press events. The CPU reads these through the memory output mux when the address decoder selects this slave.

Parameters:
WIDTH, 10, number of raw input bits (1..16)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles before the debounced value changes (>=2)

Ports:
clk  input  1  system clock (the divided CPU clock)
reset  input  1  asynchronous, active-high reset
sel  input  1  slave select from address decoder
address  input  2  register offset (memAddress[1:0])
in  input  16  CPU write data (outM)
load  input  1  CPU write strobe (writeM)
rawIn  input  WIDTH  asynchronous board inputs
out  output  16  read data to memory mux, combinational
state  output  WIDTH  debounced level, for local use/LED mirroring

Behaviour:
- Reset is asynchronous and active-high: it clears all synchronizer flops, debounced state, debounce counters, edge flags and the press counter to 0, so out=0 and state=0 while in reset. Mid-debounce progress is discarded.
- Synchronizer: SYNC_STAGES flops per bit. rawIn reaches the sync output after SYNC_STAGES clocks.
- Debounce, per bit:
  - If sync == stable, the counter goes to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with sync still differing, stable <= sync and the counter goes to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Latency from a clean rawIn change to a state change is SYNC_STAGES+DEBOUNCE_CYCLES clocks.
- Edge capture: edge[i] is set in the cycle stable[i] goes 0->1. Falling edges are ignored.
- Register map (offset: read / write):
  - 0: {zero-ext, stable} / writes ignored
  - 1: {zero-ext, edge} / write-1-to-clear: edge &= ~in[WIDTH-1:0]
  - 2: pressCount[15:0] / load: pressCount <= in
  - 3: reads 16'h0000 / writes ignored
- A write occurs only when sel & load. Reads have no side effects.
- out = sel ? reg[address] : 16'h0000. The path is purely combinational, with the value valid in the same cycle, matching the CPU's inM timing.
- Simultaneous set and clear of the same edge bit: set wins (the bit ends at 1).
- pressCount increments by 1 in any cycle where >=1 new rising edge occurs, independent of how many bits rise. It wraps 16'hFFFF -> 16'h0000.
- A CPU write to offset 2 in the same cycle as an increment: the written value wins and the increment is lost.
- Bits of in above WIDTH are ignored on writes and read back as 0.

Decomposition:
- Shared package/header: register offset constants SW_REG_STATE=0, SW_REG_EDGE=1, SW_REG_COUNT=2, SW_REG_RSVD=3. The address decoder uses the same header for the slave index.
- Sub-module debounce_bit (SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, reset, rawIn, stable, rise) is instantiated WIDTH times via generate. The top level holds the edge flags, the counter and the read mux.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=10):
1. Reset asserted mid-cycle with rawIn=10'h3FF -> out=0 and state=0 immediately; after release, state=10'h3FF in 6 clocks, no earlier.
2. rawIn[0] pulses high for 3 clocks, then low -> state[0] stays 0, edge=0, pressCount=0.
3. rawIn[3] held high for 10 clocks -> state=10'h008; read offset 1 = 16'h0008; offset 2 = 16'h0001. Then write 16'h0008 to offset 1 -> offset 1 reads 0.
4. Write 16'hFFFF to offset 2, then one clean press -> offset 2 reads 16'h0000 (wrap).
5. Write-1-to-clear to offset 1 for bit 5 in the exact cycle stable[5] rises -> edge[5]=1 afterwards. pressCount also increments.
6. sel=0 with address=1 and load=1, in=16'hFFFF -> out=0, edge flags unchanged; writes to offsets 0 and 3 have no effect.
